controller_multi: RTL and testbench
===================================

CONTROLLER_MULTI -- requirements
Module: controller_multi

Interface
REQ-001 Parameter TOKEN_W, default 3, width of the system and user tokens.
REQ-002 Parameter TIME_W, default 8, width of the time stamp.
REQ-003 Parameter SLOTS, default 4, number of parking slots, 2..16; SLOT_W = clog2(SLOTS).
REQ-004 Parameter MAX_TRIES, default 3, number of consecutive token mismatches that triggers lockout.
REQ-005 Parameter TIMEOUT, default 15, maximum number of cycles spent waiting for confirm.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low. Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- system_token  in  TOKEN_W  token latched during setup.
- request  in  1  user requests a slot operation.
- slot_id  in  SLOT_W  requested slot, sampled together with request.
- confirm  in  1  user token is valid.
- user_token  in  TOKEN_W  token entered by the user.
- time_data  in  TIME_W  current time stamp.
- data_to_save  out  TIME_W  time stamp for the slot register.
- enable_slot  out  SLOTS  one-hot, 1-cycle write enable for the slot register.
- occupied  out  SLOTS  occupancy map.
- grant  out  1  1-cycle pulse: operation accepted.
- denied  out  1  1-cycle pulse: operation rejected.
- locked  out  1  block is in lockout.
- busy  out  1  a request is in progress.

Function
REQ-007 The FSM SHALL have the states SETUP, ACTIVE, REQ_PROC, SAVE and LOCKED.
REQ-008 SETUP SHALL latch system_token into the stored token on the first clock edge after reset release, then move to ACTIVE.
REQ-009 ACTIVE, on request=1, SHALL latch slot_id and clear the timeout counter.
- slot_id < SLOTS: go to REQ_PROC.
- slot_id >= SLOTS: pulse denied and stay in ACTIVE.
REQ-010 request SHALL be ignored in every state other than ACTIVE.
REQ-011 REQ_PROC, on confirm=1, SHALL compare user_token with the stored token.
- Match: go to SAVE.
- Mismatch: increment the fail counter and pulse denied; go to LOCKED if the counter reaches MAX_TRIES, otherwise to ACTIVE.
REQ-012 REQ_PROC SHALL count the cycles spent waiting for confirm. After TIMEOUT cycles with confirm=0 it SHALL pulse denied and return to ACTIVE without changing the fail counter.
REQ-013 If confirm=1 in the same cycle as timeout expiry, confirm SHALL win.
REQ-014 SAVE SHALL last exactly one cycle and SHALL, in that cycle:
- drive data_to_save = time_data;
- assert enable_slot[latched slot] only;
- pulse grant;
- toggle occupied[latched slot] (0 = entry, 1 = exit);
- clear the fail counter;
- then return to ACTIVE.
REQ-015 Latency SHALL be:
- request to REQ_PROC: 1 cycle;
- confirm to SAVE: 1 cycle;
- grant and enable_slot: asserted during the SAVE cycle, registered outputs.
REQ-016 data_to_save SHALL hold its last saved value outside SAVE.
REQ-017 busy SHALL be 1 in REQ_PROC and SAVE, and 0 otherwise.
REQ-018 LOCKED SHALL hold locked=1 and ignore all inputs until reset_n=0.
REQ-019 grant and denied SHALL never be 1 in the same cycle.
REQ-020 enable_slot SHALL have at most one bit set in any cycle.
REQ-021 The fail counter SHALL saturate at MAX_TRIES.

Reset
REQ-022 While reset_n=0, the block SHALL be in SETUP with every output 0: data_to_save, enable_slot, occupied, grant, denied, locked, busy.
REQ-023 While reset_n=0, the stored token, fail counter, timeout counter and latched slot SHALL all be 0.
REQ-024 Reset asserted mid-operation, including during SAVE, SHALL abort immediately with no enable_slot pulse and SHALL clear the occupancy map.

Verification
REQ-025 Entry: reset, system_token=3'b101; request, slot_id=2; user_token=3'b101, confirm; time_data=8'hF0 -> enable_slot=4'b0100 for 1 cycle, data_to_save=8'hF0, grant pulse, occupied=4'b0100.
REQ-026 Exit: repeat the entry on slot 2 with time_data=8'h3C -> enable_slot=4'b0100, data_to_save=8'h3C, occupied=4'b0000.
REQ-027 Lockout: three requests each confirmed with user_token=3'b010 -> denied pulse on each, locked=1 after the third; further requests give no grant.
REQ-028 Timeout: request, confirm held 0 for 15 cycles -> denied pulse, busy=0, fail counter unchanged (two subsequent mismatches do not lock).
REQ-029 Invalid slot and ignored request: SLOTS=3, slot_id=3 -> immediate denied, state stays ACTIVE; request asserted during REQ_PROC -> ignored.
REQ-030 Reset during SAVE: reset_n=0 on the SAVE cycle -> no enable_slot pulse, all outputs 0, re-enters SETUP.

Source files
------------

// File: rtl/controller_multi.sv
// Token-guarded parking slot controller: a confirmed request toggles a slot's occupancy and
// produces a one-cycle write of the time stamp. Repeated bad tokens lock the block until reset.
module controller_multi #(
  parameter int TOKEN_W   = 3,
  parameter int TIME_W    = 8,
  parameter int SLOTS     = 4,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 15,
  localparam int SLOT_W   = $clog2(SLOTS)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [TOKEN_W-1:0] system_token,
  input  logic               request,
  input  logic [SLOT_W-1:0]  slot_id,
  input  logic               confirm,
  input  logic [TOKEN_W-1:0] user_token,
  input  logic [TIME_W-1:0]  time_data,
  output logic [TIME_W-1:0]  data_to_save,
  output logic [SLOTS-1:0]   enable_slot,
  output logic [SLOTS-1:0]   occupied,
  output logic               grant,
  output logic               denied,
  output logic               locked,
  output logic               busy
);

  // state    | meaning
  // SETUP    | latch system_token, then go active
  // ACTIVE   | idle, waiting for a request
  // REQ_PROC | waiting for confirm, timeout running
  // SAVE     | one-cycle write of time stamp into the slot, toggle occupancy
  // LOCKED   | too many bad tokens, only reset leaves

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    SETUP    = 3'd0,
    ACTIVE   = 3'd1,
    REQ_PROC = 3'd2,
    SAVE     = 3'd3,
    LOCKED   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [TOKEN_W-1:0]   tok_q, tok_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [FAIL_W-1:0]    fail_q, fail_d, fail_inc;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 grant_d, deny_d;
  logic                 grant_q, deny_q;
  logic [SLOTS-1:0]     en_q, occ_q, slot_hot;
  logic [TIME_W-1:0]    save_q;

  assign slot_hot = SLOTS'(1) << slot_q;
  assign fail_inc = (fail_q == FAIL_W'(MAX_TRIES)) ? fail_q : fail_q + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= SETUP;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tok_d   = tok_q;
    slot_d  = slot_q;
    fail_d  = fail_q;
    tmr_d   = tmr_q;
    grant_d = 1'b0;
    deny_d  = 1'b0;
    case (state_q)
      SETUP: begin
        tok_d   = system_token;
        state_d = ACTIVE;
      end
      ACTIVE: begin
        if (request) begin
          slot_d = slot_id;
          // timeout is a down-counter: loaded here, expires at terminal count 0
          tmr_d  = TMR_W'(TIMEOUT - 1);
          if (32'(slot_id) < 32'(SLOTS)) state_d = REQ_PROC;
          else                           deny_d  = 1'b1;
        end
      end
      REQ_PROC: begin
        if (confirm) begin
          if (user_token == tok_q) begin
            state_d = SAVE;
            grant_d = 1'b1;
          end else begin
            fail_d  = fail_inc;
            deny_d  = 1'b1;
            state_d = (fail_inc == FAIL_W'(MAX_TRIES)) ? LOCKED : ACTIVE;
          end
        end else if (tmr_q == '0) begin
          deny_d  = 1'b1;
          state_d = ACTIVE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      SAVE: begin
        fail_d  = '0;
        state_d = ACTIVE;
      end
      LOCKED: state_d = LOCKED;
      default: state_d = SETUP;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tok_q   <= '0;
      slot_q  <= '0;
      fail_q  <= '0;
      tmr_q   <= '0;
      grant_q <= 1'b0;
      deny_q  <= 1'b0;
      en_q    <= '0;
      occ_q   <= '0;
      save_q  <= '0;
    end else begin
      tok_q   <= tok_d;
      slot_q  <= slot_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
      grant_q <= grant_d;
      deny_q  <= deny_d;
      en_q    <= grant_d ? slot_hot : '0;
      occ_q   <= grant_d ? (occ_q ^ slot_hot) : occ_q;
      if (state_q == SAVE) save_q <= time_data;
    end
  end

  assign data_to_save = (state_q == SAVE) ? time_data : save_q;
  assign enable_slot  = en_q;
  assign occupied     = occ_q;
  assign grant        = grant_q;
  assign denied       = deny_q;
  assign locked       = (state_q == LOCKED);
  assign busy         = (state_q == REQ_PROC) || (state_q == SAVE);

endmodule

// File: tb/tb_controller_multi.sv
// Directed bench for controller_multi: vector table of full transactions plus hand sequences
// for timeout, confirm-at-expiry, ignored request, invalid slot and reset during SAVE.
module tb_controller_multi;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] system_token = 3'b101;
  logic       request = 1'b0;
  logic [1:0] slot_id = '0;
  logic       confirm = 1'b0;
  logic [2:0] user_token = '0;
  logic [7:0] time_data = '0;

  logic [7:0] data_to_save;
  logic [3:0] enable_slot, occupied;
  logic       grant, denied, locked, busy;

  logic [7:0] d3;
  logic [2:0] e3, o3;
  logic       g3, n3, l3, b3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  controller_multi u_dut (
    .clock(clock), .reset_n(reset_n), .system_token(system_token), .request(request),
    .slot_id(slot_id), .confirm(confirm), .user_token(user_token), .time_data(time_data),
    .data_to_save(data_to_save), .enable_slot(enable_slot), .occupied(occupied),
    .grant(grant), .denied(denied), .locked(locked), .busy(busy)
  );

  controller_multi #(.SLOTS(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .system_token(system_token), .request(request),
    .slot_id(slot_id), .confirm(confirm), .user_token(user_token), .time_data(time_data),
    .data_to_save(d3), .enable_slot(e3), .occupied(o3),
    .grant(g3), .denied(n3), .locked(l3), .busy(b3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    check("grant_denied_exclusive", 32'(grant & denied), 32'd0);
    check("enable_onehot0", 32'($onehot0(enable_slot)), 32'd1);
  end

  task automatic do_reset(input logic [2:0] tok);
    reset_n = 1'b0; request = 1'b0; confirm = 1'b0; system_token = tok;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic run_txn(input logic [1:0] s, input logic [2:0] tok, input logic [7:0] t,
                         output bit g, output bit d, output logic [3:0] en,
                         output int en_cyc, output int lat, output bit bz);
    g = 0; d = 0; en = '0; en_cyc = 0; lat = -1;
    @(negedge clock); request = 1'b1; slot_id = s; time_data = t;
    @(negedge clock); request = 1'b0; bz = busy; user_token = tok; confirm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); confirm = 1'b0;
      if ((grant || denied) && lat < 0) lat = i;
      g |= grant; d |= denied; en |= enable_slot;
      if (enable_slot != '0) en_cyc++;
    end
  endtask

  typedef struct {
    logic [1:0] slot; logic [2:0] tok; logic [7:0] t;
    bit g; bit d; logic [3:0] en; logic [7:0] dat; logic [3:0] occ; bit lk; bit bz;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit g, d, bz, seen;
    logic [3:0] en;
    int en_cyc, lat, busy_cnt;

    // slot tok t | grant denied en dat occ locked busy
    vecs[0] = '{2'd2, 3'b101, 8'hF0, 1, 0, 4'b0100, 8'hF0, 4'b0100, 0, 1};
    vecs[1] = '{2'd2, 3'b101, 8'h3C, 1, 0, 4'b0100, 8'h3C, 4'b0000, 0, 1};
    vecs[2] = '{2'd0, 3'b101, 8'h11, 1, 0, 4'b0001, 8'h11, 4'b0001, 0, 1};
    vecs[3] = '{2'd3, 3'b010, 8'h22, 0, 1, 4'b0000, 8'h11, 4'b0001, 0, 1};
    vecs[4] = '{2'd1, 3'b101, 8'h33, 1, 0, 4'b0010, 8'h33, 4'b0011, 0, 1};
    vecs[5] = '{2'd3, 3'b010, 8'h44, 0, 1, 4'b0000, 8'h33, 4'b0011, 0, 1};
    vecs[6] = '{2'd3, 3'b010, 8'h45, 0, 1, 4'b0000, 8'h33, 4'b0011, 0, 1};
    vecs[7] = '{2'd3, 3'b111, 8'h46, 0, 1, 4'b0000, 8'h33, 4'b0011, 1, 1};
    vecs[8] = '{2'd0, 3'b101, 8'h55, 0, 0, 4'b0000, 8'h33, 4'b0011, 1, 0};

    // outputs while reset held
    @(negedge clock);
    check("reset_outputs", {data_to_save, enable_slot, occupied, grant, denied, locked, busy}, '0);
    check("reset_outputs3", {d3, e3, o3, g3, n3, l3, b3}, '0);

    do_reset(3'b101);
    for (int k = 0; k < 9; k++) begin
      run_txn(vecs[k].slot, vecs[k].tok, vecs[k].t, g, d, en, en_cyc, lat, bz);
      check($sformatf("v%0d_grant", k), 32'(g), 32'(vecs[k].g));
      check($sformatf("v%0d_denied", k), 32'(d), 32'(vecs[k].d));
      check($sformatf("v%0d_enable", k), 32'(en), 32'(vecs[k].en));
      check($sformatf("v%0d_en_cycles", k), 32'(en_cyc), 32'(vecs[k].g ? 1 : 0));
      check($sformatf("v%0d_latency", k), 32'(lat), (vecs[k].g || vecs[k].d) ? 32'd0 : 32'hFFFF_FFFF);
      check($sformatf("v%0d_data", k), 32'(data_to_save), 32'(vecs[k].dat));
      check($sformatf("v%0d_occupied", k), 32'(occupied), 32'(vecs[k].occ));
      check($sformatf("v%0d_locked", k), 32'(locked), 32'(vecs[k].lk));
      check($sformatf("v%0d_busy", k), 32'(bz), 32'(vecs[k].bz));
    end

    // timeout: confirm never comes
    do_reset(3'b101);
    @(negedge clock); request = 1'b1; slot_id = 2'd1; time_data = 8'h77;
    @(negedge clock); request = 1'b0;
    busy_cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (denied) seen = 1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clock);
      end
    end
    check("timeout_denied_seen", 32'(seen), 32'd1);
    check("timeout_busy_cycles", 32'(busy_cnt), 32'd15);
    check("timeout_busy_after", 32'(busy), 32'd0);
    check("timeout_no_grant", 32'(grant), 32'd0);
    run_txn(2'd0, 3'b010, 8'h01, g, d, en, en_cyc, lat, bz);
    run_txn(2'd0, 3'b010, 8'h02, g, d, en, en_cyc, lat, bz);
    check("timeout_two_miss_denied", 32'(d), 32'd1);
    check("timeout_two_miss_unlocked", 32'(locked), 32'd0);
    run_txn(2'd0, 3'b010, 8'h03, g, d, en, en_cyc, lat, bz);
    check("timeout_third_miss_locked", 32'(locked), 32'd1);

    // confirm arrives on the expiry cycle
    do_reset(3'b101);
    @(negedge clock); request = 1'b1; slot_id = 2'd3; time_data = 8'h5A;
    @(negedge clock); request = 1'b0;
    repeat (14) @(negedge clock);
    user_token = 3'b101; confirm = 1'b1;
    @(negedge clock); confirm = 1'b0;
    check("expiry_confirm_grant", 32'(grant), 32'd1);
    check("expiry_confirm_denied", 32'(denied), 32'd0);
    check("expiry_confirm_enable", 32'(enable_slot), 32'b1000);
    check("expiry_confirm_data", 32'(data_to_save), 32'h5A);

    // request during REQ_PROC is ignored
    do_reset(3'b101);
    @(negedge clock); request = 1'b1; slot_id = 2'd1; time_data = 8'h21;
    @(negedge clock); request = 1'b0;
    @(negedge clock); request = 1'b1; slot_id = 2'd0;
    @(negedge clock); request = 1'b0; user_token = 3'b101; confirm = 1'b1;
    @(negedge clock); confirm = 1'b0;
    check("ignored_req_grant", 32'(grant), 32'd1);
    check("ignored_req_enable", 32'(enable_slot), 32'b0010);
    @(negedge clock);
    check("ignored_req_idle", 32'(busy), 32'd0);
    check("ignored_req_occupied", 32'(occupied), 32'b0010);

    // invalid slot on the three-slot instance
    do_reset(3'b101);
    @(negedge clock); request = 1'b1; slot_id = 2'd3;
    @(negedge clock); request = 1'b0;
    check("invalid_slot_denied", 32'(n3), 32'd1);
    check("invalid_slot_busy", 32'(b3), 32'd0);
    @(negedge clock);
    check("invalid_slot_pulse_end", 32'(n3), 32'd0);
    request = 1'b1; slot_id = 2'd2;
    @(negedge clock); request = 1'b0;
    check("invalid_slot_then_active", 32'(b3), 32'd1);

    // reset landing on the SAVE edge
    do_reset(3'b101);
    run_txn(2'd1, 3'b101, 8'h10, g, d, en, en_cyc, lat, bz);
    check("rst_save_pre_occupied", 32'(occupied), 32'b0010);
    @(negedge clock); request = 1'b1; slot_id = 2'd0; time_data = 8'h99;
    @(negedge clock); request = 1'b0; user_token = 3'b101; confirm = 1'b1;
    @(posedge clock); reset_n = 1'b0;
    #1;
    check("rst_save_outputs", {data_to_save, enable_slot, occupied, grant, denied, locked, busy}, '0);
    @(negedge clock); confirm = 1'b0; system_token = 3'b011;
    check("rst_save_outputs_held", {data_to_save, enable_slot, occupied, grant, denied, locked, busy}, '0);
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    run_txn(2'd2, 3'b011, 8'hAB, g, d, en, en_cyc, lat, bz);
    check("rst_save_new_token_grant", 32'(g), 32'd1);
    check("rst_save_new_enable", 32'(en), 32'b0100);
    check("rst_save_new_occupied", 32'(occupied), 32'b0100);
    run_txn(2'd2, 3'b101, 8'hCD, g, d, en, en_cyc, lat, bz);
    check("rst_save_old_token_denied", 32'(d), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted finish");
    $fatal(1);
  end

endmodule
